// File: rtl/ref_trim_pkg.sv
// ref_trim_pkg: shared state encoding and field widths for the reference trim controller.
package ref_trim_pkg;
  typedef enum logic [2:0] {OFF, LOAD, SETTLE, CHECK, READY, FAULT} state_t;
  localparam int TRIMBG_W = 7;
  localparam int TRIMREF_W = 5;
  localparam int FRAME_W = 13;
endpackage

// File: rtl/ref_trim_sync.sv
// ref_trim_sync: two-flop synchronizer for the asynchronous refok flag.
module ref_trim_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/ref_trim_ctrl.sv
// ref_trim_ctrl: serial trim load, reference power-up, settle/retry check; REF_TRIM_TEST_EN adds trim override.
module ref_trim_ctrl
  import ref_trim_pkg::*;
#(
  parameter int SETTLE_CYC = 256,
  parameter int RETRY_MAX = 3,
  parameter logic [TRIMBG_W-1:0] TRIMBG_DEF = 7'h40,
  parameter logic [TRIMREF_W-1:0] TRIMREF_DEF = 5'h10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic sdata,
  input  logic svalid,
  output logic sready,
  input  logic refok,
  output logic en,
  output logic [TRIMBG_W-1:0] trimBG,
  output logic [TRIMREF_W-1:0] trimREF,
  output logic ten_bg,
  output logic ten_ref,
`ifdef REF_TRIM_TEST_EN
  input  logic tm_en,
  input  logic [11:0] tm_code,
`endif
  output logic ready,
  output logic fault
);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);
  state_t state, state_nx;
  logic [FRAME_W-2:0] frame;
  logic [FRAME_W-1:0] full;
  logic [3:0] bit_cnt;
  logic [CW-1:0] settle_cnt;
  logic [RW-1:0] retry, retry_inc;
  logic [TRIMBG_W-1:0] bg_q;
  logic [TRIMREF_W-1:0] ref_q;
  logic refok_s, accept, last_bit, par_ok;
  ref_trim_sync u_sync (.clk(clk), .rst(rst), .d(refok), .q(refok_s));
  assign sready = state == LOAD;
  assign ready = state == READY;
  assign fault = state == FAULT;
  assign accept = sready & svalid;
  assign last_bit = accept && bit_cnt == 4'(FRAME_W - 1);
  // The 13th bit is decoded straight off sdata, so only 12 bits need storing.
  assign full = {frame, sdata};
  assign par_ok = ~^full;
  assign retry_inc = retry + 1'b1;
  always_comb begin
    state_nx = state;
    case (state)
      OFF:     state_nx = start ? LOAD : OFF;
      LOAD:    state_nx = last_bit ? (par_ok ? SETTLE : FAULT) : LOAD;
      SETTLE:  state_nx = settle_cnt == '0 ? CHECK : SETTLE;
      CHECK:   state_nx = refok_s ? READY : (retry_inc < RW'(RETRY_MAX) ? SETTLE : FAULT);
      READY:   state_nx = refok_s ? READY : FAULT;
      FAULT:   state_nx = start ? LOAD : FAULT;
      default: state_nx = OFF;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= OFF;
      frame <= '0;
      bit_cnt <= '0;
      settle_cnt <= '0;
      retry <= '0;
      bg_q <= TRIMBG_DEF;
      ref_q <= TRIMREF_DEF;
      en <= 1'b0;
    end else begin
      state <= state_nx;
      if (state != LOAD && state_nx == LOAD) begin
        frame <= '0;
        bit_cnt <= '0;
        retry <= '0;
      end else if (accept) begin
        frame <= last_bit ? '0 : full[FRAME_W-2:0];
        bit_cnt <= last_bit ? '0 : bit_cnt + 4'd1;
      end
      if (last_bit && par_ok) begin
        bg_q <= full[FRAME_W-1 -: TRIMBG_W];
        ref_q <= full[TRIMREF_W:1];
        en <= 1'b1;
      end
      if (state != SETTLE && state_nx == SETTLE) settle_cnt <= CW'(SETTLE_CYC - 1);
      else if (state == SETTLE) settle_cnt <= settle_cnt - 1'b1;
      if (state == CHECK && !refok_s) retry <= retry_inc;
    end
`ifdef REF_TRIM_TEST_EN
  logic ten;
  logic [11:0] tm_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ten <= 1'b0;
      tm_q <= '0;
    end else begin
      ten <= tm_en && (state == READY || state == FAULT);
      tm_q <= tm_code;
    end
  assign ten_bg = ten;
  assign ten_ref = ten;
  assign trimBG = ten ? tm_q[11:5] : bg_q;
  assign trimREF = ten ? tm_q[4:0] : ref_q;
`else
  assign ten_bg = 1'b0;
  assign ten_ref = 1'b0;
  assign trimBG = bg_q;
  assign trimREF = ref_q;
`endif
endmodule

// File: tb/tb_ref_trim_ctrl.sv
// tb_ref_trim_ctrl: directed self-checking bench for ref_trim_ctrl.
module tb_ref_trim_ctrl;
  localparam int S = 8;
  localparam logic [12:0] GOOD1 = {7'h55, 5'h0A, 1'b0};
  localparam logic [12:0] BAD1 = {7'h55, 5'h0A, 1'b1};
  localparam logic [12:0] GOOD2 = {7'h12, 5'h07, 1'b1};
  logic clk = 1'b0, rst, start, sdata, svalid, refok;
  logic sready, en, ten_bg, ten_ref, ready, fault;
  logic [6:0] trimBG;
  logic [4:0] trimREF;
  int n_cmp = 0, n_bad = 0;
`ifdef REF_TRIM_TEST_EN
  logic tm_en;
  logic [11:0] tm_code;
`endif
  ref_trim_ctrl #(.SETTLE_CYC(S), .RETRY_MAX(3)) dut (
    .clk(clk), .rst(rst), .start(start), .sdata(sdata), .svalid(svalid), .sready(sready),
    .refok(refok), .en(en), .trimBG(trimBG), .trimREF(trimREF), .ten_bg(ten_bg), .ten_ref(ten_ref),
`ifdef REF_TRIM_TEST_EN
    .tm_en(tm_en), .tm_code(tm_code),
`endif
    .ready(ready), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [12:0] f, input bit stall);
    for (int i = 12; i >= 0; i--) begin
      sdata = f[i];
      svalid = 1'b1;
      step();
      if (stall && i == 7) begin
        svalid = 1'b0;
        repeat (3) step();
        chk("stall_sready", sready, 1);
        chk("stall_en", en, 0);
      end
    end
    svalid = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; sdata = 1'b0; svalid = 1'b0; refok = 1'b0;
`ifdef REF_TRIM_TEST_EN
    tm_en = 1'b0; tm_code = '0;
`endif
    #3;
    chk("rst_en", en, 0);
    chk("rst_bg", trimBG, 7'h40);
    chk("rst_ref", trimREF, 5'h10);
    chk("rst_sready", sready, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ten", {ten_bg, ten_ref}, 0);
    repeat (2) step();
    rst = 1'b0;
    refok = 1'b1;
    pulse_start();
    chk("load_sready", sready, 1);
    send_frame(BAD1, 0);
    chk("bad_fault", fault, 1);
    chk("bad_en", en, 0);
    chk("bad_bg", trimBG, 7'h40);
    chk("bad_ref", trimREF, 5'h10);
    chk("bad_sready", sready, 0);
    pulse_start();
    chk("reload_fault", fault, 0);
    chk("reload_sready", sready, 1);
    send_frame(GOOD1, 1);
    chk("good_en", en, 1);
    chk("good_bg", trimBG, 7'h55);
    chk("good_ref", trimREF, 5'h0A);
    chk("good_sready", sready, 0);
    repeat (S) step();
    chk("check_ready", ready, 0);
    step();
    chk("ready_on", ready, 1);
    pulse_start();
    chk("ready_ignores_start", ready, 1);
    chk("ready_sready", sready, 0);
`ifdef REF_TRIM_TEST_EN
    tm_code = 12'hFFF;
    tm_en = 1'b1;
    step();
    chk("tm_bg", trimBG, 7'h7F);
    chk("tm_ref", trimREF, 5'h1F);
    chk("tm_ten", {ten_bg, ten_ref}, 2'b11);
    tm_en = 1'b0;
    step();
    chk("tm_off_bg", trimBG, 7'h55);
    chk("tm_off_ref", trimREF, 5'h0A);
    chk("tm_off_ten", {ten_bg, ten_ref}, 0);
`else
    chk("ten_const", {ten_bg, ten_ref}, 0);
`endif
    refok = 1'b0;
    repeat (2) step();
    chk("drop_ready_hold", ready, 1);
    chk("drop_fault_hold", fault, 0);
    step();
    chk("drop_ready", ready, 0);
    chk("drop_fault", fault, 1);
    chk("drop_en", en, 1);
    pulse_start();
    chk("recover_fault", fault, 0);
    chk("recover_sready", sready, 1);
    chk("recover_en", en, 1);
    chk("recover_bg", trimBG, 7'h55);
    chk("recover_ref", trimREF, 5'h0A);
    send_frame(GOOD2, 0);
    chk("g2_bg", trimBG, 7'h12);
    chk("g2_ref", trimREF, 5'h07);
    repeat (3 * S + 2) step();
    chk("retry_fault_late", fault, 0);
    step();
    chk("retry_fault", fault, 1);
    chk("retry_en", en, 1);
    refok = 1'b1;
    pulse_start();
    for (int i = 12; i >= 7; i--) begin
      sdata = GOOD2[i];
      svalid = 1'b1;
      step();
    end
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_en", en, 0);
    chk("mid_rst_bg", trimBG, 7'h40);
    chk("mid_rst_ref", trimREF, 5'h10);
    chk("mid_rst_sready", sready, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_ready", ready, 0);
    #2 rst = 1'b0;
    repeat (4) begin
      sdata = 1'b1;
      svalid = 1'b1;
      step();
    end
    svalid = 1'b0;
    chk("stray_sready", sready, 0);
    chk("stray_en", en, 0);
    chk("stray_fault", fault, 0);
    pulse_start();
    send_frame(GOOD1, 0);
    chk("after_rst_en", en, 1);
    chk("after_rst_bg", trimBG, 7'h55);
    chk("after_rst_ref", trimREF, 5'h0A);
    repeat (S + 1) step();
    chk("after_rst_ready", ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
